move_request_ctrl: RTL and testbench
====================================

MOVE_REQUEST_CTRL -- requirements
Module: move_request_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and RST.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- RST  in  1  synchronous reset
- start  in  1  move request strobe
- player  in  1  side to move; 1=WHITE, 0=BLACK
- from_sq  in  6  source square 0..63
- to_sq  in  6  destination square 0..63
- location_vectors_w  in  96  white piece squares; piece i at bits [6i+5:6i]
- location_vectors_b  in  96  black piece squares, same packing
- alive_vectors_w  in  16  white alive bits; bit i = piece i
- alive_vectors_b  in  16  black alive bits
- upd_done  in  1  completion from board-update stage
- upd_en  out  1  one-cycle move issue to board-update stage
- upd_piece_number  out  4  piece index (K1=0 .. P1=15)
- upd_move  out  6  destination square
- upd_player  out  1  side issued
- busy  out  1  request in progress
- accept  out  1  one-cycle pulse: move applied
- reject  out  1  one-cycle pulse: move refused
- reject_code  out  2  00 NO_PIECE, 01 OWN_BLOCK, 10 SAME_SQ, 11 TIMEOUT; valid with reject
REQ-003 SHALL have parameter TIMEOUT_CYC, default 15: maximum WAIT_DONE cycles.

Function
REQ-004 States SHALL be IDLE, SCAN, CHECK, ISSUE, WAIT_DONE and REPORT.
REQ-005 IDLE: start=1 SHALL capture player, from_sq and to_sq. If from_sq==to_sq, next state is REPORT with SAME_SQ; otherwise next state is SCAN with scan index 15.
REQ-006 start SHALL be ignored outside IDLE; no queuing.
REQ-007 SCAN SHALL examine one own-side piece per cycle, descending from index 15; match = slice==from_sq and alive bit==1.
REQ-008 On a match, SCAN SHALL latch the index and go to CHECK. No match at index 0 SHALL give REPORT with NO_PIECE (16 SCAN cycles).
REQ-009 CHECK (1 cycle) SHALL compare all 16 own alive slices against to_sq in parallel. Any hit gives REPORT with OWN_BLOCK; otherwise ISSUE. Opponent occupancy is legal (capture).
REQ-010 ISSUE (1 cycle) SHALL drive upd_en=1 with upd_piece_number, upd_move=to_sq and upd_player all stable. Those three outputs SHALL hold until the block returns to IDLE.
REQ-011 upd_en SHALL be high only in ISSUE: exactly one cycle per accepted request.
REQ-012 WAIT_DONE SHALL ignore upd_done in the cycle of and the cycle after ISSUE. It then waits for upd_done=1 and goes to REPORT with success.
REQ-013 WAIT_DONE SHALL count cycles; reaching TIMEOUT_CYC without upd_done gives REPORT with TIMEOUT.
REQ-014 REPORT (1 cycle) SHALL pulse exactly one of accept or reject, then return to IDLE.
REQ-015 busy SHALL be 1 in every non-IDLE state, including REPORT.
REQ-016 Location and alive vectors SHALL be sampled live, not captured. They are stable while busy because this block is the only writer.
REQ-017 A start arriving in the same cycle as REPORT SHALL be ignored.

Reset
REQ-018 With RST=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-SCAN and mid-WAIT_DONE.
REQ-019 Reset values SHALL be: upd_en=0, upd_piece_number=0, upd_move=0, upd_player=1, busy=0, accept=0, reject=0, reject_code=0; scan index and timeout counter cleared.
REQ-020 No upd_en SHALL be issued in the cycle RST is asserted or the cycle after.

Structure
REQ-021 A shared package SHALL hold: piece indices P1..K1; WHITE/BLACK; reject codes; square width 6; initial white and black location constants used by the board-update stage.
REQ-022 One sub-module, piece_slice_sel, SHALL return the 6-bit square and alive bit for a given index and side. It is used by SCAN.
REQ-023 The CHECK comparators SHALL live in this module.

Verification
REQ-024 Reset, then white, from=8, to=16, start; upd_done pulses 2 cycles after upd_en -> upd_piece_number=15, upd_move=16, upd_player=1; accept after 1 SCAN cycle.
REQ-025 Reset, then white, from=20, to=28 -> reject, code 00, after 16 SCAN cycles; upd_en never asserted.
REQ-026 Reset, then white, from=0 (R1, idx 7), to=1 (own N1) -> SCAN finds idx 7 in 9th cycle; reject, code 01.
REQ-027 from=to=8 -> reject, code 10, in the cycle after start; black, from=48, to=40 -> upd_piece_number=15, upd_player=0, accept.
REQ-028 Valid move with upd_done held 0 -> reject, code 11, after 15 WAIT_DONE cycles; start during busy ignored.
REQ-029 RST asserted mid-SCAN -> next cycle busy=0 and all outputs at reset values; a following valid request completes normally.

Source files
------------

// File: rtl/move_request_ctrl_pkg.sv
// Shared definitions for the move request controller and the board-update stage.
package move_request_ctrl_pkg;

  localparam int unsigned SQ_W       = 6;
  localparam int unsigned NUM_PIECES = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned LOC_W      = SQ_W * NUM_PIECES;

  // Side encoding
  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  // Piece indices within one side's vectors
  typedef enum logic [IDX_W-1:0] {
    K1 = 4'd0,
    Q1 = 4'd1,
    R2 = 4'd2,
    N2 = 4'd3,
    B2 = 4'd4,
    B1 = 4'd5,
    N1 = 4'd6,
    R1 = 4'd7,
    P8 = 4'd8,
    P7 = 4'd9,
    P6 = 4'd10,
    P5 = 4'd11,
    P4 = 4'd12,
    P3 = 4'd13,
    P2 = 4'd14,
    P1 = 4'd15
  } piece_e;

  // Reason reported alongside reject
  typedef enum logic [1:0] {
    REJ_NO_PIECE  = 2'b00,
    REJ_OWN_BLOCK = 2'b01,
    REJ_SAME_SQ   = 2'b10,
    REJ_TIMEOUT   = 2'b11
  } reject_code_e;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE,
    S_REPORT
  } state_e;

  // Starting squares for one side: back rank a..h, pawns P1 on file a up to P8 on file h
  function automatic logic [LOC_W-1:0] init_locations(input logic side);
    logic [LOC_W-1:0] v;
    logic [SQ_W-1:0]  back;
    logic [SQ_W-1:0]  pawn;
    v    = '0;
    back = (side == WHITE) ? 6'd0 : 6'd56;
    pawn = (side == WHITE) ? 6'd8 : 6'd48;
    v[int'(R1)*SQ_W +: SQ_W] = back + 6'd0;
    v[int'(N1)*SQ_W +: SQ_W] = back + 6'd1;
    v[int'(B1)*SQ_W +: SQ_W] = back + 6'd2;
    v[int'(Q1)*SQ_W +: SQ_W] = back + 6'd3;
    v[int'(K1)*SQ_W +: SQ_W] = back + 6'd4;
    v[int'(B2)*SQ_W +: SQ_W] = back + 6'd5;
    v[int'(N2)*SQ_W +: SQ_W] = back + 6'd6;
    v[int'(R2)*SQ_W +: SQ_W] = back + 6'd7;
    for (int unsigned p = 0; p < 8; p++) begin
      v[(int'(P1) - int'(p))*SQ_W +: SQ_W] = pawn + SQ_W'(p);
    end
    return v;
  endfunction

  localparam logic [LOC_W-1:0]      INIT_LOC_W = init_locations(WHITE);
  localparam logic [LOC_W-1:0]      INIT_LOC_B = init_locations(BLACK);
  localparam logic [NUM_PIECES-1:0] INIT_ALIVE = '1;

endpackage

// File: rtl/move_request_ctrl_piece_slice_sel.sv
// Selects one piece's square and alive bit from the packed side vectors.
module piece_slice_sel
  import move_request_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0]      idx,
  input  logic                  side,
  input  logic [LOC_W-1:0]      loc_w,
  input  logic [LOC_W-1:0]      loc_b,
  input  logic [NUM_PIECES-1:0] alive_w,
  input  logic [NUM_PIECES-1:0] alive_b,
  output logic [SQ_W-1:0]       sq,
  output logic                  alive
);

  logic [LOC_W-1:0]      loc_sel;
  logic [NUM_PIECES-1:0] alive_sel;

  // Pick the side, then the indexed slice
  always_comb begin
    loc_sel   = (side == WHITE) ? loc_w : loc_b;
    alive_sel = (side == WHITE) ? alive_w : alive_b;
    sq        = loc_sel[idx*SQ_W +: SQ_W];
    alive     = alive_sel[idx];
  end

endmodule

// File: rtl/move_request_ctrl.sv
// Move request controller: locates the moving piece, checks the destination
// against own pieces, issues the move to the board-update stage and reports.
module move_request_ctrl
  import move_request_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  player,
  input  logic [SQ_W-1:0]       from_sq,
  input  logic [SQ_W-1:0]       to_sq,
  input  logic [LOC_W-1:0]      location_vectors_w,
  input  logic [LOC_W-1:0]      location_vectors_b,
  input  logic [NUM_PIECES-1:0] alive_vectors_w,
  input  logic [NUM_PIECES-1:0] alive_vectors_b,
  input  logic                  upd_done,
  output logic                  upd_en,
  output logic [IDX_W-1:0]      upd_piece_number,
  output logic [SQ_W-1:0]       upd_move,
  output logic                  upd_player,
  output logic                  busy,
  output logic                  accept,
  output logic                  reject,
  output logic [1:0]            reject_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state;
  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    piece_idx;
  logic [CNT_W-1:0]    wait_cnt;
  logic                player_q;
  logic [SQ_W-1:0]     from_q;
  logic [SQ_W-1:0]     to_q;

  logic [SQ_W-1:0]       scan_sq;
  logic                  scan_alive;
  logic                  scan_match;
  logic [NUM_PIECES-1:0] own_hit;
  logic                  own_block;

  piece_slice_sel u_slice (
    .idx     (scan_idx),
    .side    (player_q),
    .loc_w   (location_vectors_w),
    .loc_b   (location_vectors_b),
    .alive_w (alive_vectors_w),
    .alive_b (alive_vectors_b),
    .sq      (scan_sq),
    .alive   (scan_alive)
  );

  assign scan_match = scan_alive && (scan_sq == from_q);

  // Destination compared against every live own piece at once
  always_comb begin
    own_hit = '0;
    for (int unsigned i = 0; i < NUM_PIECES; i++) begin
      if (player_q == WHITE) begin
        own_hit[i] = alive_vectors_w[i] && (location_vectors_w[i*SQ_W +: SQ_W] == to_q);
      end else begin
        own_hit[i] = alive_vectors_b[i] && (location_vectors_b[i*SQ_W +: SQ_W] == to_q);
      end
    end
  end

  assign own_block = |own_hit;

  // Request sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      state            <= S_IDLE;
      scan_idx         <= '0;
      piece_idx        <= '0;
      wait_cnt         <= '0;
      player_q         <= WHITE;
      from_q           <= '0;
      to_q             <= '0;
      upd_en           <= 1'b0;
      upd_piece_number <= '0;
      upd_move         <= '0;
      upd_player       <= WHITE;
      busy             <= 1'b0;
      accept           <= 1'b0;
      reject           <= 1'b0;
      reject_code      <= '0;
    end else begin
      upd_en <= 1'b0;
      accept <= 1'b0;
      reject <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            player_q <= player;
            from_q   <= from_sq;
            to_q     <= to_sq;
            busy     <= 1'b1;
            if (from_sq == to_sq) begin
              state       <= S_REPORT;
              reject      <= 1'b1;
              reject_code <= REJ_SAME_SQ;
            end else begin
              state    <= S_SCAN;
              scan_idx <= IDX_W'(NUM_PIECES - 1);
            end
          end
        end

        S_SCAN: begin
          if (scan_match) begin
            piece_idx <= scan_idx;
            state     <= S_CHECK;
          end else if (scan_idx == '0) begin
            state       <= S_REPORT;
            reject      <= 1'b1;
            reject_code <= REJ_NO_PIECE;
          end else begin
            scan_idx <= scan_idx - 1'b1;
          end
        end

        S_CHECK: begin
          if (own_block) begin
            state       <= S_REPORT;
            reject      <= 1'b1;
            reject_code <= REJ_OWN_BLOCK;
          end else begin
            state            <= S_ISSUE;
            upd_en           <= 1'b1;
            upd_piece_number <= piece_idx;
            upd_move         <= to_q;
            upd_player       <= player_q;
          end
        end

        S_ISSUE: begin
          state    <= S_WAIT_DONE;
          wait_cnt <= '0;
        end

        // First WAIT_DONE cycle (count 0) is the cycle after ISSUE, where upd_done is ignored
        S_WAIT_DONE: begin
          if ((wait_cnt != '0) && upd_done) begin
            state  <= S_REPORT;
            accept <= 1'b1;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state       <= S_REPORT;
            reject      <= 1'b1;
            reject_code <= REJ_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_REPORT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_request_ctrl.sv
// Self-checking bench for move_request_ctrl with a rule-level reference model.
module tb_move_request_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic        player;
  logic [5:0]  from_sq;
  logic [5:0]  to_sq;
  logic [95:0] location_vectors_w;
  logic [95:0] location_vectors_b;
  logic [15:0] alive_vectors_w;
  logic [15:0] alive_vectors_b;
  logic        upd_done;
  logic        upd_en;
  logic [3:0]  upd_piece_number;
  logic [5:0]  upd_move;
  logic        upd_player;
  logic        busy;
  logic        accept;
  logic        reject;
  logic [1:0]  reject_code;

  move_request_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk                (clk),
    .RST                (RST),
    .start              (start),
    .player             (player),
    .from_sq            (from_sq),
    .to_sq              (to_sq),
    .location_vectors_w (location_vectors_w),
    .location_vectors_b (location_vectors_b),
    .alive_vectors_w    (alive_vectors_w),
    .alive_vectors_b    (alive_vectors_b),
    .upd_done           (upd_done),
    .upd_en             (upd_en),
    .upd_piece_number   (upd_piece_number),
    .upd_move           (upd_move),
    .upd_player         (upd_player),
    .busy               (busy),
    .accept             (accept),
    .reject             (reject),
    .reject_code        (reject_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side board
  logic [5:0]  wl [16];
  logic [5:0]  bl [16];
  logic [15:0] aw;
  logic [15:0] ab;

  // Observations from the last request
  int         o_lat, o_en_cnt, o_en_cyc;
  bit         o_acc, o_rej, o_busy_ok, o_hold_ok, o_idle_ok;
  logic [1:0] o_code;
  logic [3:0] o_piece;
  logic [5:0] o_move;
  logic       o_player;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_board();
    for (int i = 0; i < 16; i++) begin
      location_vectors_w[i*6 +: 6] = wl[i];
      location_vectors_b[i*6 +: 6] = bl[i];
    end
    alive_vectors_w = aw;
    alive_vectors_b = ab;
  endtask

  task automatic initial_board();
    int back_off [8];
    back_off = '{4, 3, 7, 6, 5, 2, 1, 0};
    for (int i = 0; i < 8; i++) begin
      wl[i] = 6'(back_off[i]);
      bl[i] = 6'(56 + back_off[i]);
    end
    for (int i = 8; i < 16; i++) begin
      wl[i] = 6'(8 + 15 - i);
      bl[i] = 6'(48 + 15 - i);
    end
    aw = '1;
    ab = '1;
    apply_board();
  endtask

  // Expected outcome from the rules: cycles counted from the start edge
  function automatic void model(input bit p, input int f, input int t, input int d,
                                output int lat, output bit acc, output logic [1:0] code,
                                output int en_cyc, output int piece);
    int  found;
    bit  blocked;
    int  s;
    acc = 0; code = 2'd0; en_cyc = -1; piece = -1; found = -1; blocked = 0;
    if (f == t) begin
      lat = 1; code = 2'd2;
      return;
    end
    for (int i = 15; i >= 0; i--) begin
      if (found < 0 && (p ? aw[i] : ab[i]) && int'(p ? wl[i] : bl[i]) == f) found = i;
    end
    if (found < 0) begin
      lat = 17; code = 2'd0;
      return;
    end
    s = 16 - found;
    for (int i = 0; i < 16; i++) begin
      if ((p ? aw[i] : ab[i]) && int'(p ? wl[i] : bl[i]) == t) blocked = 1;
    end
    if (blocked) begin
      lat = s + 2; code = 2'd1;
      return;
    end
    en_cyc = s + 2;
    piece  = found;
    if (d >= 2 && d <= TMO) begin
      lat = en_cyc + d + 1; acc = 1;
    end else begin
      lat = en_cyc + TMO + 1; code = 2'd3;
    end
  endfunction

  // Drives one request and records what the DUT did; d = upd_done delay after upd_en (-1 never)
  task automatic do_request(input bit p, input int f, input int t, input int d, input bit poke);
    o_lat = -1; o_en_cnt = 0; o_en_cyc = -1; o_acc = 0; o_rej = 0; o_code = 2'd0;
    o_busy_ok = 1; o_hold_ok = 1; o_idle_ok = 0;
    o_piece = '0; o_move = '0; o_player = 1'b0;
    player = p; from_sq = 6'(f); to_sq = 6'(t); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (busy !== 1'b1) o_busy_ok = 0;
      if (upd_en === 1'b1) begin
        o_en_cnt++;
        if (o_en_cnt == 1) begin
          o_en_cyc = c; o_piece = upd_piece_number; o_move = upd_move; o_player = upd_player;
        end
      end
      if (o_en_cyc > 0 && (upd_piece_number !== o_piece || upd_move !== o_move ||
                           upd_player !== o_player)) o_hold_ok = 0;
      upd_done = (o_en_cyc > 0 && d >= 0 && c == o_en_cyc + d);
      if (poke && c == 3) begin
        start = 1'b1; player = ~p; from_sq = 6'(t); to_sq = 6'(f);
      end else begin
        start = 1'b0;
      end
      if (accept === 1'b1 || reject === 1'b1) begin
        o_lat = c; o_acc = accept; o_rej = reject; o_code = reject_code;
        break;
      end
      tick();
    end
    upd_done = 1'b0;
    start    = 1'b0;
    tick();
    o_idle_ok = (busy === 1'b0 && accept === 1'b0 && reject === 1'b0 && upd_en === 1'b0);
  endtask

  task automatic test_reset();
    n_cmp++; if (upd_en !== 1'b0) begin n_bad++; $display("FAIL rst_upd_en got=%b want=0", upd_en); end
    n_cmp++; if (upd_piece_number !== 4'd0) begin n_bad++; $display("FAIL rst_piece got=%0d want=0", upd_piece_number); end
    n_cmp++; if (upd_move !== 6'd0) begin n_bad++; $display("FAIL rst_move got=%0d want=0", upd_move); end
    n_cmp++; if (upd_player !== 1'b1) begin n_bad++; $display("FAIL rst_player got=%b want=1", upd_player); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_cmp++; if (accept !== 1'b0 || reject !== 1'b0) begin n_bad++; $display("FAIL rst_pulses got=%b%b want=00", accept, reject); end
    n_cmp++; if (reject_code !== 2'd0) begin n_bad++; $display("FAIL rst_code got=%0d want=0", reject_code); end
  endtask

  task automatic test_directed();
    initial_board();
    // White P1 8->16, done two cycles after issue
    do_request(1, 8, 16, 2, 0);
    n_cmp++; if (o_lat !== 6 || o_acc !== 1 || o_rej !== 0) begin n_bad++; $display("FAIL w_pawn_accept got lat=%0d acc=%b rej=%b want lat=6 acc=1 rej=0", o_lat, o_acc, o_rej); end
    n_cmp++; if (o_en_cnt !== 1 || o_en_cyc !== 3) begin n_bad++; $display("FAIL w_pawn_issue got cnt=%0d cyc=%0d want cnt=1 cyc=3", o_en_cnt, o_en_cyc); end
    n_cmp++; if (o_piece !== 4'd15 || o_move !== 6'd16 || o_player !== 1'b1) begin n_bad++; $display("FAIL w_pawn_fields got %0d/%0d/%b want 15/16/1", o_piece, o_move, o_player); end
    n_cmp++; if (!o_busy_ok || !o_hold_ok || !o_idle_ok) begin n_bad++; $display("FAIL w_pawn_busy_hold got %b%b%b want 111", o_busy_ok, o_hold_ok, o_idle_ok); end
    // Empty source square
    do_request(1, 20, 28, 2, 0);
    n_cmp++; if (o_lat !== 17 || o_rej !== 1 || o_acc !== 0 || o_code !== 2'd0) begin n_bad++; $display("FAIL no_piece got lat=%0d rej=%b code=%0d want lat=17 rej=1 code=0", o_lat, o_rej, o_code); end
    n_cmp++; if (o_en_cnt !== 0) begin n_bad++; $display("FAIL no_piece_issue got cnt=%0d want 0", o_en_cnt); end
    // R1 onto own N1
    do_request(1, 0, 1, 2, 0);
    n_cmp++; if (o_lat !== 11 || o_rej !== 1 || o_code !== 2'd1 || o_en_cnt !== 0) begin n_bad++; $display("FAIL own_block got lat=%0d rej=%b code=%0d en=%0d want lat=11 rej=1 code=1 en=0", o_lat, o_rej, o_code, o_en_cnt); end
    // Same square
    do_request(1, 8, 8, 2, 0);
    n_cmp++; if (o_lat !== 1 || o_rej !== 1 || o_code !== 2'd2 || !o_idle_ok) begin n_bad++; $display("FAIL same_sq got lat=%0d rej=%b code=%0d idle=%b want lat=1 rej=1 code=2 idle=1", o_lat, o_rej, o_code, o_idle_ok); end
    // Black P1 48->40
    do_request(0, 48, 40, 2, 0);
    n_cmp++; if (o_lat !== 6 || o_acc !== 1 || o_piece !== 4'd15 || o_move !== 6'd40 || o_player !== 1'b0) begin n_bad++; $display("FAIL b_pawn got lat=%0d acc=%b %0d/%0d/%b want lat=6 acc=1 15/40/0", o_lat, o_acc, o_piece, o_move, o_player); end
  endtask

  task automatic test_timeout();
    initial_board();
    // P2 9->17, upd_done never, stray start while busy
    do_request(1, 9, 17, -1, 1);
    n_cmp++; if (o_lat !== 20 || o_rej !== 1 || o_code !== 2'd3) begin n_bad++; $display("FAIL timeout got lat=%0d rej=%b code=%0d want lat=20 rej=1 code=3", o_lat, o_rej, o_code); end
    n_cmp++; if (o_en_cnt !== 1 || !o_idle_ok || !o_hold_ok) begin n_bad++; $display("FAIL timeout_busy_start got en=%0d idle=%b hold=%b want 1 1 1", o_en_cnt, o_idle_ok, o_hold_ok); end
    // upd_done in the last allowed cycle
    do_request(1, 10, 18, TMO, 0);
    n_cmp++; if (o_lat !== 21 || o_acc !== 1) begin n_bad++; $display("FAIL done_last got lat=%0d acc=%b want lat=21 acc=1", o_lat, o_acc); end
    // upd_done only in the cycle after issue must be ignored
    do_request(1, 11, 19, 1, 0);
    n_cmp++; if (o_lat !== 22 || o_rej !== 1 || o_code !== 2'd3) begin n_bad++; $display("FAIL done_early got lat=%0d rej=%b code=%0d want lat=22 rej=1 code=3", o_lat, o_rej, o_code); end
  endtask

  task automatic test_reset_mid_scan();
    initial_board();
    player = 1'b1; from_sq = 6'd20; to_sq = 6'd28; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_cmp++; if (busy !== 1'b0 || upd_en !== 1'b0 || accept !== 1'b0 || reject !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctrl got busy=%b en=%b acc=%b rej=%b want 0000", busy, upd_en, accept, reject); end
    n_cmp++; if (upd_piece_number !== 4'd0 || upd_move !== 6'd0 || upd_player !== 1'b1 || reject_code !== 2'd0) begin n_bad++; $display("FAIL mid_rst_fields got %0d/%0d/%b/%0d want 0/0/1/0", upd_piece_number, upd_move, upd_player, reject_code); end
    tick();
    n_cmp++; if (upd_en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_after got en=%b busy=%b want 0 0", upd_en, busy); end
    do_request(1, 8, 16, 3, 0);
    n_cmp++; if (o_lat !== 7 || o_acc !== 1 || o_en_cnt !== 1) begin n_bad++; $display("FAIL mid_rst_recover got lat=%0d acc=%b en=%0d want 7 1 1", o_lat, o_acc, o_en_cnt); end
  endtask

  task automatic test_back_to_back();
    initial_board();
    player = 1'b1; from_sq = 6'd8; to_sq = 6'd8; start = 1'b1;
    tick();
    // REPORT cycle: a start here must be dropped
    from_sq = 6'd8; to_sq = 6'd16; start = 1'b1;
    n_cmp++; if (reject !== 1'b1) begin n_bad++; $display("FAIL b2b_report got rej=%b want 1", reject); end
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_start_in_report got busy=%b want 0", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0 || upd_en !== 1'b0) begin n_bad++; $display("FAIL b2b_still_idle got busy=%b en=%b want 0 0", busy, upd_en); end
  endtask

  task automatic test_random();
    int lat, en_cyc, piece, f, t, d, k;
    bit p, acc;
    logic [1:0] code;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) begin
        wl[i] = 6'($urandom_range(0, 63));
        bl[i] = 6'($urandom_range(0, 63));
      end
      aw = 16'($urandom) | 16'($urandom);
      ab = 16'($urandom) | 16'($urandom);
      apply_board();
      p = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 15);
      f = ($urandom_range(0, 3) != 0) ? int'(p ? wl[k] : bl[k]) : $urandom_range(0, 63);
      k = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: t = $urandom_range(0, 63);
        1: t = int'(p ? wl[k] : bl[k]);
        2: t = f;
        default: t = int'(p ? bl[k] : wl[k]);
      endcase
      d = $urandom_range(0, 17);
      if (d > TMO) d = -1;
      model(p, f, t, d, lat, acc, code, en_cyc, piece);
      do_request(p, f, t, d, 0);
      n_cmp++; if (o_lat !== lat || o_acc !== acc || o_rej !== !acc) begin n_bad++; $display("FAIL rnd%0d_outcome got lat=%0d acc=%b rej=%b want lat=%0d acc=%b", n, o_lat, o_acc, o_rej, lat, acc); end
      if (!acc) begin
        n_cmp++; if (o_code !== code) begin n_bad++; $display("FAIL rnd%0d_code got=%0d want=%0d", n, o_code, code); end
      end
      n_cmp++; if (o_en_cyc !== en_cyc || o_en_cnt !== (en_cyc > 0 ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_issue got cyc=%0d cnt=%0d want cyc=%0d", n, o_en_cyc, o_en_cnt, en_cyc); end
      if (en_cyc > 0) begin
        n_cmp++; if (o_piece !== 4'(piece) || o_move !== 6'(t) || o_player !== p) begin n_bad++; $display("FAIL rnd%0d_fields got %0d/%0d/%b want %0d/%0d/%b", n, o_piece, o_move, o_player, piece, t, p); end
      end
      n_cmp++; if (!o_busy_ok || !o_hold_ok || !o_idle_ok) begin n_bad++; $display("FAIL rnd%0d_busy_hold got %b%b%b want 111", n, o_busy_ok, o_hold_ok, o_idle_ok); end
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; player = 1'b0; from_sq = '0; to_sq = '0; upd_done = 1'b0;
    initial_board();
    tick();
    tick();
    test_reset();
    RST = 1'b0;
    tick();
    test_directed();
    test_reset_mid_scan();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
